pds_rx: RTL and testbench

- Receive-side endpoint of the PDS packet interface; it is the DUT the class-based driver feeds.
- Accepts byte-serial packets (single-port or multicast), decodes the header, and forwards payload bytes with a destination port mask.
- Checks length and XOR checksum, then reports per-packet status plus good/error counters to the monitor.
- Sits between the PDS ingress interface and the per-port egress logic.

---
 rtl/pds_rx.sv | 235 +++++++++++++++++++++++
 tb/tb_pds_rx.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pds_rx.sv
// ---------------------------------------------------------------------------
// pds_rx : receive-side endpoint of the PDS packet interface.
//
// Accepts byte-serial packets on the ingress side, decodes the header
// (single-port or multicast), forwards payload bytes with a destination
// port mask through a one-stage egress register, verifies length and the
// XOR checksum, and reports per-packet status plus saturating good/error
// packet counters.
//
// Ingress packet:  HDR [7]=mc [2:0]=portno | MASK (mc only) | LEN |
//                  LEN payload bytes | CHK (XOR of all preceding bytes, eop)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   ingress byte valid
//   in_sop     ingress first byte (header)
//   in_eop     ingress last byte (checksum)
//   in_data    ingress byte
//   in_ready   ingress accept (transfer = in_valid & in_ready)
//   out_valid  egress payload byte valid
//   out_data   egress payload byte
//   out_mask   egress destination port mask
//   out_sop    egress first payload byte
//   out_eop    egress last payload byte
//   out_ready  egress backpressure
//   pkt_done   one-cycle pulse at packet end
//   pkt_ok     packet status, qualified by pkt_done
//   pkt_cnt    count of good packets (saturating)
//   err_cnt    count of errored packets (saturating)
// ---------------------------------------------------------------------------
module pds_rx #(
   parameter int unsigned NUM_PORTS = 8,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 in_sop,
   input  logic                 in_eop,
   input  logic [7:0]           in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [7:0]           out_data,
   output logic [NUM_PORTS-1:0] out_mask,
   output logic                 out_sop,
   output logic                 out_eop,
   input  logic                 out_ready,
   output logic                 pkt_done,
   output logic                 pkt_ok,
   output logic [CNT_W-1:0]     pkt_cnt,
   output logic [CNT_W-1:0]     err_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MASK,
      S_LEN,
      S_PAYLOAD,
      S_CHK,
      S_DONE
   } state_t;

   state_t               state;
   logic [7:0]           xor_acc;    // running XOR of accepted packet bytes
   logic [7:0]           len_rem;    // payload bytes still expected
   logic [NUM_PORTS-1:0] mask;       // destination mask of current packet
   logic                 drop;       // packet has no valid destination
   logic                 first;      // next payload byte is the first one

   logic                 xfer;
   logic                 fin;        // current transfer ends a packet
   logic                 fin_ok;     // ...and that packet is good
   logic                 load;       // current transfer fills egress register
   logic [NUM_PORTS-1:0] hdr_mask;   // one-hot of header portno (0 if out of range)

   // -----------------------------------------------------------------------
   // Ingress accept
   // -----------------------------------------------------------------------
   always_comb begin
      in_ready = 1'b1;
      case (state)
         S_PAYLOAD: in_ready = !out_valid || out_ready;
         S_DONE:    in_ready = 1'b0;
         default:   in_ready = 1'b1;
      endcase
   end

   assign xfer = in_valid && in_ready;

   // -----------------------------------------------------------------------
   // Header port decode; a portno beyond NUM_PORTS yields an empty mask,
   // which is what marks a single-port packet as dropped.
   // -----------------------------------------------------------------------
   always_comb begin
      hdr_mask = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (32'(in_data[2:0]) == i) begin
            hdr_mask[i] = 1'b1;
         end
      end
   end

   // -----------------------------------------------------------------------
   // Packet termination decision for the current transfer.
   // A sop outside IDLE closes the running packet as an error in the same
   // cycle the new header is taken, so both packets are accounted for.
   // -----------------------------------------------------------------------
   always_comb begin
      fin    = 1'b0;
      fin_ok = 1'b0;
      if (xfer) begin
         if (state == S_IDLE) begin
            fin = in_sop && in_eop;            // header-only packet: early end
         end else if (in_sop) begin
            fin = 1'b1;                        // truncated packet
         end else if (state == S_CHK) begin
            fin    = 1'b1;
            fin_ok = in_eop && (in_data == xor_acc) && !drop;
         end else begin
            fin = in_eop;                      // early end before CHK
         end
      end
   end

   assign load = xfer && (state == S_PAYLOAD) && !in_sop && !drop;

   // -----------------------------------------------------------------------
   // FSM, egress register, status and counters
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         xor_acc   <= '0;
         len_rem   <= '0;
         mask      <= '0;
         drop      <= 1'b0;
         first     <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_mask  <= '0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         pkt_done  <= 1'b0;
         pkt_ok    <= 1'b0;
         pkt_cnt   <= '0;
         err_cnt   <= '0;
      end else begin
         // status pulse and saturating counters
         pkt_done <= fin;
         pkt_ok   <= fin_ok;
         if (fin) begin
            if (fin_ok) begin
               if (pkt_cnt != '1) begin
                  pkt_cnt <= pkt_cnt + CNT_W'(1);
               end
            end else begin
               if (err_cnt != '1) begin
                  err_cnt <= err_cnt + CNT_W'(1);
               end
            end
         end

         // egress register: load only when the slot is free (guaranteed by
         // in_ready), otherwise drain on out_ready
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_mask  <= mask;
            out_sop   <= first;
            // an early eop on a payload byte closes the egress packet too
            out_eop   <= (len_rem == 8'd1) || in_eop;
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
         end

         // packet FSM
         case (state)
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               if (xfer) begin
                  if (in_sop) begin
                     // new header, whether from IDLE or truncating a packet
                     xor_acc <= in_data;
                     mask    <= hdr_mask;
                     drop    <= !in_data[7] && (hdr_mask == '0);
                     first   <= 1'b0;
                     len_rem <= '0;
                     if (in_eop) begin
                        state <= S_DONE;
                     end else if (in_data[7]) begin
                        state <= S_MASK;
                     end else begin
                        state <= S_LEN;
                     end
                  end else if (state == S_IDLE) begin
                     state <= S_IDLE;          // stray byte, discarded
                  end else if ((state == S_CHK) || in_eop) begin
                     state <= S_DONE;
                  end else begin
                     xor_acc <= xor_acc ^ in_data;
                     case (state)
                        S_MASK: begin
                           mask  <= in_data[NUM_PORTS-1:0];
                           drop  <= (in_data[NUM_PORTS-1:0] == '0);
                           state <= S_LEN;
                        end
                        S_LEN: begin
                           len_rem <= in_data;
                           first   <= 1'b1;
                           state   <= (in_data == 8'd0) ? S_CHK : S_PAYLOAD;
                        end
                        S_PAYLOAD: begin
                           len_rem <= len_rem - 8'd1;
                           first   <= 1'b0;
                           if (len_rem == 8'd1) begin
                              state <= S_CHK;
                           end
                        end
                        default: begin
                           state <= state;
                        end
                     endcase
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pds_rx.sv
// ---------------------------------------------------------------------------
// tb_pds_rx : directed and randomized bench for pds_rx.
// Expected egress bytes and packet status come from a packet-level model
// (destination mask from header/mask byte, payload list, checksum validity).
// ---------------------------------------------------------------------------
module tb_pds_rx;

   localparam int unsigned NP = 8;
   localparam int unsigned CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_sop = 1'b0;
   logic          in_eop = 1'b0;
   logic [7:0]    in_data = '0;
   logic          in_ready;
   logic          out_valid;
   logic [7:0]    out_data;
   logic [NP-1:0] out_mask;
   logic          out_sop;
   logic          out_eop;
   logic          out_ready = 1'b1;
   logic          pkt_done;
   logic          pkt_ok;
   logic [CW-1:0] pkt_cnt;
   logic [CW-1:0] err_cnt;

   pds_rx #(.NUM_PORTS(NP), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_sop    (in_sop),
      .in_eop    (in_eop),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_mask  (out_mask),
      .out_sop   (out_sop),
      .out_eop   (out_eop),
      .out_ready (out_ready),
      .pkt_done  (pkt_done),
      .pkt_ok    (pkt_ok),
      .pkt_cnt   (pkt_cnt),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   logic rand_bp = 1'b0;
   logic force_ready = 1'b1;

   // egress entry: {mask, sop, eop, data}
   logic [NP+9:0] cap_q[$];
   logic [NP+9:0] exp_q[$];
   logic          done_q[$];
   logic          exp_done[$];
   logic [7:0]    pay[$];
   int unsigned   m_pkt = 0;
   int unsigned   m_err = 0;
   int unsigned   hold_err = 0;
   logic          stall_d = 1'b0;
   logic [NP+9:0] stall_v = '0;

   // egress backpressure
   always @(posedge clk) begin
      #2;
      out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : force_ready;
   end

   // egress / status capture and hold-stability watch
   always @(negedge clk) begin
      if (rst) begin
         stall_d <= 1'b0;
      end else begin
         if (out_valid && out_ready) cap_q.push_back({out_mask, out_sop, out_eop, out_data});
         if (pkt_done) done_q.push_back(pkt_ok);
         if (stall_d && (!out_valid || ({out_mask, out_sop, out_eop, out_data} != stall_v)))
            hold_err <= hold_err + 1;
         stall_d <= out_valid && !out_ready;
         stall_v <= {out_mask, out_sop, out_eop, out_data};
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
      int unsigned t;
      if (rand_bp && ($urandom_range(0, 3) == 0)) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_sop   = s;
      in_eop   = e;
      t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("in_ready_wait", 32'(t < 200), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
   endtask

   // sends HDR [MASK] LEN payload CHK(eop); flip corrupts the checksum
   task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] mbyte, input logic [7:0] flip);
      logic [7:0] x;
      x = hdr;
      send_byte(hdr, 1'b1, 1'b0);
      if (hdr[7]) begin
         x ^= mbyte;
         send_byte(mbyte, 1'b0, 1'b0);
      end
      x ^= 8'(pay.size());
      send_byte(8'(pay.size()), 1'b0, 1'b0);
      foreach (pay[i]) begin
         x ^= pay[i];
         send_byte(pay[i], 1'b0, 1'b0);
      end
      send_byte(x ^ flip, 1'b0, 1'b1);
   endtask

   // packet-level reference model
   task automatic model_pkt(input logic [7:0] hdr, input logic [7:0] mbyte, input logic corrupt);
      logic [NP-1:0] eff;
      int unsigned   port;
      logic          ok;
      port = 32'(hdr[2:0]);
      if (hdr[7])          eff = mbyte[NP-1:0];
      else if (port < NP)  eff = NP'(1) << port;
      else                 eff = '0;
      if (eff != '0) begin
         foreach (pay[i]) exp_q.push_back({eff, (i == 0), (i == pay.size() - 1), pay[i]});
      end
      ok = (eff != '0) && !corrupt;
      exp_done.push_back(ok);
      if (ok) m_pkt++;
      else    m_err++;
   endtask

   task automatic finish_check(input string tag);
      int unsigned t;
      t = 0;
      while ((done_q.size() < exp_done.size()) && t < 400) begin
         @(negedge clk);
         t++;
      end
      check({tag, ":done_wait"}, 32'(t < 400), 32'd1);
      t = 0;
      while (out_valid && t < 400) begin
         @(negedge clk);
         t++;
      end
      check({tag, ":drain_wait"}, 32'(t < 400), 32'd1);
      @(negedge clk);
      check({tag, ":done_count"}, 32'(done_q.size()), 32'(exp_done.size()));
      for (int i = 0; i < done_q.size() && i < exp_done.size(); i++)
         check($sformatf("%s:pkt_ok[%0d]", tag, i), 32'(done_q[i]), 32'(exp_done[i]));
      check({tag, ":byte_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s:byte[%0d]", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
      check({tag, ":pkt_cnt"}, 32'(pkt_cnt), m_pkt);
      check({tag, ":err_cnt"}, 32'(err_cnt), m_err);
      check({tag, ":hold"}, hold_err, 32'd0);
      cap_q.delete();
      exp_q.delete();
      done_q.delete();
      exp_done.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ":out_valid"}, 32'(out_valid), 32'd0);
      check({tag, ":out_data"},  32'(out_data),  32'd0);
      check({tag, ":out_mask"},  32'(out_mask),  32'd0);
      check({tag, ":out_sop"},   32'(out_sop),   32'd0);
      check({tag, ":out_eop"},   32'(out_eop),   32'd0);
      check({tag, ":pkt_done"},  32'(pkt_done),  32'd0);
      check({tag, ":pkt_ok"},    32'(pkt_ok),    32'd0);
      check({tag, ":pkt_cnt"},   32'(pkt_cnt),   32'd0);
      check({tag, ":err_cnt"},   32'(err_cnt),   32'd0);
      check({tag, ":in_ready"},  32'(in_ready),  32'd1);
   endtask

   initial begin
      logic [7:0] hdr, mb, flip;
      logic       corrupt;

      // power-on reset
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst = 1'b0;

      // reset mid-payload abandons the packet silently
      send_byte(8'h04, 1'b1, 1'b0);
      send_byte(8'h03, 1'b0, 1'b0);
      send_byte(8'h77, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("mid_rst");
      check("mid_rst:no_done", 32'(done_q.size()), 32'd0);
      rst = 1'b0;
      cap_q.delete();
      done_q.delete();

      // single-port packet
      pay = '{8'hAA, 8'h55};
      model_pkt(8'h04, 8'h00, 1'b0);
      send_pkt(8'h04, 8'h00, 8'h00);
      finish_check("single");

      // multicast packet
      pay = '{8'h3C};
      model_pkt(8'h80, 8'h81, 1'b0);
      send_pkt(8'h80, 8'h81, 8'h00);
      finish_check("mcast");

      // backpressure: egress stalled for 3 cycles after first byte
      pay = '{8'hAA, 8'h55};
      model_pkt(8'h04, 8'h00, 1'b0);
      send_byte(8'h04, 1'b1, 1'b0);
      send_byte(8'h02, 1'b0, 1'b0);
      send_byte(8'hAA, 1'b0, 1'b0);
      force_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("bp:in_ready", 32'(in_ready), 32'd0);
         check("bp:out_valid", 32'(out_valid), 32'd1);
         check("bp:out_data", 32'(out_data), 32'hAA);
      end
      force_ready = 1'b1;
      send_byte(8'h55, 1'b0, 1'b0);
      send_byte(8'h04 ^ 8'h02 ^ 8'hAA ^ 8'h55, 1'b0, 1'b1);
      finish_check("bp");

      // bad checksum: CHK byte sent as 0x00
      pay = '{8'hAA, 8'h55};
      model_pkt(8'h04, 8'h00, 1'b1);
      send_pkt(8'h04, 8'h00, 8'h04 ^ 8'h02 ^ 8'hAA ^ 8'h55);
      finish_check("badchk");

      // truncation: new sop after one payload byte of LEN=3
      exp_q.push_back({8'h04, 1'b1, 1'b0, 8'h11});
      exp_done.push_back(1'b0);
      m_err++;
      send_byte(8'h02, 1'b1, 1'b0);
      send_byte(8'h03, 1'b0, 1'b0);
      send_byte(8'h11, 1'b0, 1'b0);
      pay = '{8'hAA, 8'h55};
      model_pkt(8'h04, 8'h00, 1'b0);
      send_pkt(8'h04, 8'h00, 8'h00);
      finish_check("trunc");

      // multicast with empty mask is dropped
      pay = '{8'h12, 8'h34};
      model_pkt(8'h80, 8'h00, 1'b0);
      send_pkt(8'h80, 8'h00, 8'h00);
      finish_check("drop");

      // zero-length packet
      pay.delete();
      model_pkt(8'h01, 8'h00, 1'b0);
      send_pkt(8'h01, 8'h00, 8'h00);
      finish_check("len0");

      // early end: eop on second payload byte of LEN=4
      exp_q.push_back({8'h20, 1'b1, 1'b0, 8'h10});
      exp_q.push_back({8'h20, 1'b0, 1'b1, 8'h20});
      exp_done.push_back(1'b0);
      m_err++;
      send_byte(8'h05, 1'b1, 1'b0);
      send_byte(8'h04, 1'b0, 1'b0);
      send_byte(8'h10, 1'b0, 1'b0);
      send_byte(8'h20, 1'b0, 1'b1);
      finish_check("early");

      // overlong: correct CHK without eop, then a stray byte discarded
      exp_q.push_back({8'h08, 1'b1, 1'b1, 8'h5A});
      exp_done.push_back(1'b0);
      m_err++;
      send_byte(8'h03, 1'b1, 1'b0);
      send_byte(8'h01, 1'b0, 1'b0);
      send_byte(8'h5A, 1'b0, 1'b0);
      send_byte(8'h03 ^ 8'h01 ^ 8'h5A, 1'b0, 1'b0);
      send_byte(8'h99, 1'b0, 1'b1);
      finish_check("overlong");

      // randomized packets with random backpressure and ingress gaps
      rand_bp = 1'b1;
      for (int n = 0; n < 40; n++) begin
         hdr = 8'($urandom);
         mb  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
         pay.delete();
         for (int k = 0; k < int'($urandom_range(0, 10)); k++) pay.push_back(8'($urandom));
         corrupt = ($urandom_range(0, 4) == 0);
         flip    = corrupt ? 8'($urandom_range(1, 255)) : 8'h00;
         model_pkt(hdr, mb, corrupt);
         send_pkt(hdr, mb, flip);
         finish_check($sformatf("rand%0d", n));
      end
      rand_bp = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
